div_hilo_unit: RTL and testbench

// - Multi-cycle radix-2 restoring divider in the execute stage, downstream of the decode/execute control pipeline.
// - Consumes the DIV/DIVU request decoded in execute: start, signedness and the two GPR operands.
// - Returns remainder (hi_o) and quotient (lo_o) for the HI/LO write path.
// - Raises div_stall so the hazard unit holds IF..EX while a divide is in flight.

---
 rtl/div_hilo_unit_if.sv | 25 ++
 rtl/div_hilo_unit.sv | 152 +++++++++++++++
 tb/tb_div_hilo_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/div_hilo_unit_if.sv
// Request/result bundle between the execute-stage control and the HI/LO divider.
// The master drives the decoded divide request; the slave returns the stall, the done pulse and HI/LO.
interface div_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             startE;
    logic             signE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             cancel;
    logic             div_stall;
    logic             done;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output startE, signE, srcaE, srcbE, cancel,
        input  div_stall, done, hi_o, lo_o
    );

    modport slave (
        input  startE, signE, srcaE, srcbE, cancel,
        output div_stall, done, hi_o, lo_o
    );
endinterface

// File: rtl/div_hilo_unit.sv
// Multi-cycle radix-2 restoring divider returning remainder on hi_o and quotient on lo_o.
// Optional DIV_ZERO_FAST_EN: a zero divisor bypasses the iterations and finishes in two cycles.
module div_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    div_hilo_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               accept;
    logic               load;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     rem_sh;
    logic               no_borrow;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    // One restoring step: shift the next dividend bit into the partial remainder and try the divisor.
    always_comb begin
        mag_a     = magnitude(bus.srcaE, bus.signE);
        mag_b     = magnitude(bus.srcbE, bus.signE);
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        no_borrow = (rem_sh >= {1'b0, dvs_q});
        rem_step  = no_borrow ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], no_borrow};
    end

    assign accept = bus.startE & ~bus.cancel;
    assign load   = accept & ((state_q == IDLE) | (state_q == DONE));

    // NOTE: every signal assigned in this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = neg_quo_q ? -quo_q : quo_q;
                hi_d    = neg_rem_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new request is taken from IDLE, or from DONE for back-to-back divides.
        if (load) begin
            neg_quo_d = bus.signE & (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
            neg_rem_d = bus.signE & bus.srcaE[WIDTH-1];
            dvs_d     = mag_b;
            cnt_d     = '0;
`ifdef DIV_ZERO_FAST_EN
            if (bus.srcbE == '0) begin
                rem_d   = mag_a;
                quo_d   = '1;
                state_d = FIX;
            end else begin
                rem_d   = '0;
                quo_d   = mag_a;
                state_d = RUN;
            end
`else
            rem_d   = '0;
            quo_d   = mag_a;
            state_d = RUN;
`endif
        end

        // Abort squashes the divide in flight and leaves the last HI/LO result intact.
        if (bus.cancel) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Stall drops in DONE so the consumer advances in the same cycle the result is presented.
    assign bus.div_stall = ((state_q == IDLE) & bus.startE) | (state_q == RUN) | (state_q == FIX);
    assign bus.done      = (state_q == DONE) & ~bus.cancel;
    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;

endmodule

// File: tb/tb_div_hilo_unit.sv
// Directed self-checking bench for div_hilo_unit: latency, stall window, sign fix-up,
// divide by zero, cancel, back-to-back and asynchronous reset.
module tb_div_hilo_unit;

    localparam int ZCYC =
`ifdef DIV_ZERO_FAST_EN
        2;
`else
        34;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    div_hilo_unit_if #(.WIDTH(32)) bus ();

    div_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the cycle startE is presented; the result must appear exactly in cycle ecyc.
    // hold: present the next DIVU request during the DONE cycle. chained: that request is already in.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] elo, input logic [31:0] ehi, input int ecyc,
                           input bit chained, input bit hold, input logic [31:0] na, input logic [31:0] nb);
        int stall_bad;
        int first_done;
        int done_cnt;
        int last;
        stall_bad  = 0;
        first_done = -1;
        done_cnt   = 0;
        last       = hold ? ecyc : ecyc + 2;
        if (!chained) begin
            bus.signE  = sgn;
            bus.srcaE  = a;
            bus.srcbE  = b;
            bus.startE = 1'b1;
        end
        for (int cyc = (chained ? 1 : 0); cyc <= last; cyc++) begin
            @(negedge clk);
            if (bus.div_stall !== (cyc < ecyc)) stall_bad++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = cyc;
            end
            if (cyc == ecyc) begin
                check({tag, " lo"}, bus.lo_o, elo);
                check({tag, " hi"}, bus.hi_o, ehi);
            end
            tick();
            if (cyc == 0 && !chained) bus.startE = 1'b0;
            if (hold && cyc == ecyc - 1) begin
                bus.signE  = 1'b0;
                bus.srcaE  = na;
                bus.srcbE  = nb;
                bus.startE = 1'b1;
            end
            if (hold && cyc == ecyc) bus.startE = 1'b0;
        end
        check({tag, " stall window errors"}, 32'(stall_bad), 32'd0);
        check({tag, " done cycle"}, 32'(first_done), 32'(ecyc));
        check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int done_seen;
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        bus.startE = 1'b0;
        bus.signE  = 1'b0;
        bus.srcaE  = '0;
        bus.srcbE  = '0;
        bus.cancel = 1'b0;

        #3;
        check("reset hi", bus.hi_o, 32'd0);
        check("reset lo", bus.lo_o, 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset stall", 32'(bus.div_stall), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 1'b0, 1'b0, '0, '0);
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 1'b0, 1'b0, '0, '0);
        run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34, 1'b0, 1'b0, '0, '0);
        run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, ZCYC, 1'b0, 1'b0, '0, '0);
        run_div("div 5/0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, ZCYC, 1'b0, 1'b0, '0, '0);
        run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, ZCYC, 1'b0, 1'b0, '0, '0);

        // Cancel in cycle 10, then a fresh divide from cycle 12.
        bus.signE  = 1'b0;
        bus.srcaE  = 32'd100;
        bus.srcbE  = 32'd7;
        bus.startE = 1'b1;
        tick();
        bus.startE = 1'b0;
        repeat (9) tick();
        bus.cancel = 1'b1;
        @(negedge clk);
        check("stall in cancel cycle", 32'(bus.div_stall), 32'd1);
        tick();
        bus.cancel = 1'b0;
        @(negedge clk);
        check("stall after cancel", 32'(bus.div_stall), 32'd0);
        check("lo kept after cancel", bus.lo_o, 32'd1);
        tick();
        run_div("divu 9/3 after cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34, 1'b0, 1'b0, '0, '0);

        // Back-to-back: 9/2 then 20/6 presented in the DONE cycle.
        run_div("divu 9/2 b2b first", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1, 34, 1'b0, 1'b1, 32'd20, 32'd6);
        run_div("divu 20/6 b2b second", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 34, 1'b1, 1'b0, '0, '0);

        // cancel together with startE drops the request.
        bus.signE  = 1'b0;
        bus.srcaE  = 32'd50;
        bus.srcbE  = 32'd5;
        bus.startE = 1'b1;
        bus.cancel = 1'b1;
        tick();
        bus.startE = 1'b0;
        bus.cancel = 1'b0;
        done_seen  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.div_stall !== 1'b0 || bus.done !== 1'b0) done_seen++;
            tick();
        end
        check("start+cancel dropped", 32'(done_seen), 32'd0);

        // Asynchronous reset in the middle of RUN.
        bus.srcaE  = 32'd100;
        bus.srcbE  = 32'd7;
        bus.startE = 1'b1;
        tick();
        bus.startE = 1'b0;
        repeat (9) tick();
        #2;
        rst = 1'b0;
        #1;
        check("async rst hi", bus.hi_o, 32'd0);
        check("async rst lo", bus.lo_o, 32'd0);
        check("async rst stall", 32'(bus.div_stall), 32'd0);
        check("async rst done", 32'(bus.done), 32'd0);
        tick();
        rst = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
            tick();
        end
        check("no done after rst", 32'(done_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
